// File: rtl/bram_fifo_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_fifo_ctl_if
// Purpose  : Bundles the producer push port, the consumer valid/ready port,
//            the status flags and the block-RAM port A/B signals of
//            bram_fifo_ctl.
// Modports : slave  - the FIFO controller (drives flags, read data, RAM
//                     controls; receives push, ready and RAM read data)
//            master - the surrounding logic (producer, consumer, RAM)
// Signals  : wr_en, wr_data, full            producer side
//            rd_valid, rd_ready, rd_data     consumer side
//            fill_cnt, ovf_err               status
//            ram_ena, ram_wea, ram_addra,
//            ram_da, ram_enb, ram_addrb,
//            ram_qb                          block RAM ports A (write), B (read)
// Revision : 1.0 - initial release
// ============================================================================
interface bram_fifo_ctl_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic                  full;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [WIDTH-1:0]      rd_data;
    logic [ADDR_WIDTH:0]   fill_cnt;
    logic                  ovf_err;
    logic                  ram_ena;
    logic                  ram_wea;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic [WIDTH-1:0]      ram_da;
    logic                  ram_enb;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic [WIDTH-1:0]      ram_qb;

    modport slave (
        input  wr_en, wr_data, rd_ready, ram_qb,
        output full, rd_valid, rd_data, fill_cnt, ovf_err,
               ram_ena, ram_wea, ram_addra, ram_da, ram_enb, ram_addrb
    );

    modport master (
        output wr_en, wr_data, rd_ready, ram_qb,
        input  full, rd_valid, rd_data, fill_cnt, ovf_err,
               ram_ena, ram_wea, ram_addra, ram_da, ram_enb, ram_addrb
    );
endinterface
`default_nettype wire

// File: rtl/bram_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module   : bram_fifo_ctl
// Purpose  : Synchronous FIFO controller around a 1W/1R block RAM whose read
//            latency is PIPELINE+1 cycles. Writes go straight to RAM port A;
//            reads are issued on port B against a credit check so that every
//            returning word fits in a small skid FIFO that feeds the
//            valid/ready output.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - bram_fifo_ctl_if.slave (push, pop, status, RAM ports)
// Options  : `define BRAM_FIFO_OVF_CHK_EN to make ovf_err a sticky flag set by
//            a push attempted while full. Without it ovf_err is tied low.
//            Pushes while full are dropped in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module bram_fifo_ctl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int PIPELINE   = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bram_fifo_ctl_if.slave  bus
);

    // RAM read latency and skid size. Two extra skid slots beyond the
    // latency let one read issue and one pop happen every cycle.
    localparam int c_LAT        = PIPELINE + 1;
    localparam int c_SKID_DEPTH = PIPELINE + 3;
    localparam int c_SK_AW      = $clog2(c_SKID_DEPTH);
    localparam int c_SK_CW      = $clog2(c_SKID_DEPTH + 1);
    localparam int c_CW         = ADDR_WIDTH + 1;

    localparam logic [c_CW-1:0]       c_DEPTH_V   = c_CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [c_SK_AW-1:0]    c_SK_ONE    = c_SK_AW'(1);
    localparam logic [c_SK_AW-1:0]    c_SK_LAST   = c_SK_AW'(c_SKID_DEPTH - 1);
    localparam logic [c_SK_CW:0]      c_SKID_LIM  = (c_SK_CW + 1)'(c_SKID_DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [c_CW-1:0]       r_mem_cnt;
    logic [c_CW-1:0]       r_fill_cnt;
    logic                  r_full;
    logic [c_LAT-1:0]      r_vld_sr;
    logic [c_SK_CW-1:0]    r_infl_cnt;
    logic [c_SK_CW-1:0]    r_sk_cnt;
    logic [c_SK_AW-1:0]    r_sk_wr;
    logic [c_SK_AW-1:0]    r_sk_rd;
    logic [WIDTH-1:0]      r_sk_mem [c_SKID_DEPTH];

    logic                  w_push;
    logic                  w_issue;
    logic                  w_ret;
    logic                  w_pop;
    logic [c_SK_CW:0]      w_occ;
    logic [c_CW-1:0]       w_fill_nxt;

    // rst gating keeps every RAM control low while reset is held, even if the
    // producer is still requesting a push.
    assign w_push  = bus.wr_en & ~r_full & ~rst;
    // Reads in flight plus words already in the skid must leave room for one
    // more return, so the skid can never be overrun.
    assign w_occ   = {1'b0, r_infl_cnt} + {1'b0, r_sk_cnt};
    assign w_issue = (r_mem_cnt != '0) & (w_occ < c_SKID_LIM);
    assign w_ret   = r_vld_sr[c_LAT-1];
    assign w_pop   = (r_sk_cnt != '0) & bus.rd_ready;

    always_comb begin
        w_fill_nxt = r_fill_cnt;
        case ({w_push, w_pop})
            2'b10:   w_fill_nxt = r_fill_cnt + c_CW'(1);
            2'b01:   w_fill_nxt = r_fill_cnt - c_CW'(1);
            default: w_fill_nxt = r_fill_cnt;
        endcase
    end

    // Pointers, counters and the read-return valid pipeline. mem_cnt only
    // sees a push one cycle later, so a word is never read in the cycle it
    // is written (the RAM is read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_fill_cnt <= '0;
            r_full     <= 1'b0;
            r_vld_sr   <= '0;
            r_infl_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_ONE;
            end
            r_mem_cnt  <= r_mem_cnt + c_CW'(w_push) - c_CW'(w_issue);
            r_fill_cnt <= w_fill_nxt;
            r_full     <= (w_fill_nxt == c_DEPTH_V);
            r_vld_sr   <= (r_vld_sr << 1) | c_LAT'(w_issue);
            r_infl_cnt <= r_infl_cnt + c_SK_CW'(w_issue) - c_SK_CW'(w_ret);
        end
    end

    // Skid FIFO: circular buffer capturing RAM data at the last latency stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sk_wr  <= '0;
            r_sk_rd  <= '0;
            r_sk_cnt <= '0;
            for (int i = 0; i < c_SKID_DEPTH; i++) begin
                r_sk_mem[i] <= '0;
            end
        end else begin
            if (w_ret) begin
                r_sk_mem[r_sk_wr] <= bus.ram_qb;
                r_sk_wr           <= (r_sk_wr == c_SK_LAST) ? '0 : r_sk_wr + c_SK_ONE;
            end
            if (w_pop) begin
                r_sk_rd <= (r_sk_rd == c_SK_LAST) ? '0 : r_sk_rd + c_SK_ONE;
            end
            r_sk_cnt <= r_sk_cnt + c_SK_CW'(w_ret) - c_SK_CW'(w_pop);
        end
    end

`ifdef BRAM_FIFO_OVF_CHK_EN
    logic r_ovf_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (bus.wr_en && r_full) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign bus.ovf_err = r_ovf_err;
`else
    assign bus.ovf_err = 1'b0;
`endif

    assign bus.full      = r_full;
    assign bus.fill_cnt  = r_fill_cnt;
    assign bus.rd_valid  = (r_sk_cnt != '0);
    assign bus.rd_data   = r_sk_mem[r_sk_rd];

    // Address/data are forced to zero when their port is idle.
    assign bus.ram_ena   = w_push;
    assign bus.ram_wea   = w_push;
    assign bus.ram_addra = w_push ? r_wr_ptr : '0;
    assign bus.ram_da    = w_push ? bus.wr_data : '0;
    assign bus.ram_enb   = w_issue;
    assign bus.ram_addrb = w_issue ? r_rd_ptr : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_fifo_ctl
// Purpose  : Self-checking bench for bram_fifo_ctl with a behavioural block
//            RAM and a queue-based reference model of the FIFO contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_fifo_ctl;

    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 16;
    localparam int PIPELINE   = 1;
`ifdef BRAM_FIFO_OVF_CHK_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    bram_fifo_ctl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    bram_fifo_ctl #(
        .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .PIPELINE(PIPELINE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural read-first RAM with PIPELINE+1 cycles of read latency.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q1 = '0;
    logic [WIDTH-1:0] q2 = '0;
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) mem[bus.ram_addra] <= bus.ram_da;
        if (bus.ram_enb) q1 <= mem[bus.ram_addrb];
        q2 <= q1;
    end
    assign bus.ram_qb = (PIPELINE != 0) ? q2 : q1;

    // Reference model state.
    logic [WIDTH-1:0] q[$];
    int               n_push, n_issue;
    bit               ovf_hit;
    bit               stall_prev;
    logic [WIDTH-1:0] stall_data;
    int               cyc;
    int               total, bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fill"},  bus.fill_cnt, 0);
        check({tag, "_full"},  bus.full, 0);
        check({tag, "_valid"}, bus.rd_valid, 0);
        check({tag, "_data"},  bus.rd_data, 0);
        check({tag, "_ovf"},   bus.ovf_err, 0);
        check({tag, "_ena"},   bus.ram_ena, 0);
        check({tag, "_wea"},   bus.ram_wea, 0);
        check({tag, "_addra"}, bus.ram_addra, 0);
        check({tag, "_da"},    bus.ram_da, 0);
        check({tag, "_enb"},   bus.ram_enb, 0);
        check({tag, "_addrb"}, bus.ram_addrb, 0);
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic step();
        bit               acc, pop;
        logic [WIDTH-1:0] d;
        #1;
        acc = bus.wr_en && (q.size() != DEPTH);
        pop = bus.rd_valid && bus.rd_ready;
        d   = bus.wr_data;
        check("ram_ena", bus.ram_ena, acc);
        check("ram_wea", bus.ram_wea, acc);
        if (acc) begin
            check("ram_addra", bus.ram_addra, n_push % DEPTH);
            check("ram_da", bus.ram_da, d);
        end
        if (bus.ram_enb) begin
            check("read_has_entry", n_issue < n_push, 1);
            check("ram_addrb", bus.ram_addrb, n_issue % DEPTH);
            n_issue++;
        end
        if (bus.rd_valid) check("valid_nonempty", q.size() != 0, 1);
        if (pop && q.size() != 0) check("rd_data", bus.rd_data, q[0]);
        if (stall_prev) begin
            check("stall_valid", bus.rd_valid, 1);
            check("stall_data", bus.rd_data, stall_data);
        end
        stall_prev = bus.rd_valid && !bus.rd_ready;
        stall_data = bus.rd_data;
        if (bus.wr_en && q.size() == DEPTH) ovf_hit = 1'b1;
        @(posedge clk);
        if (acc) begin
            q.push_back(d);
            n_push++;
        end
        if (pop && q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        check("fill_cnt", bus.fill_cnt, q.size());
        check("full", bus.full, q.size() == DEPTH);
        check("ovf_err", bus.ovf_err, OVF_ON && ovf_hit);
        cyc++;
    endtask

    task automatic drain(input string tag);
        int guard;
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        check({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        int lat, first_pop, last_pop, npops, start, acc_cnt, guard, k;
        total = 0; bad = 0; cyc = 0;
        n_push = 0; n_issue = 0; ovf_hit = 0; stall_prev = 0; stall_data = '0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single word latency.
        bus.wr_en = 1'b1; bus.wr_data = 32'hA5A5_0001; bus.rd_ready = 1'b1;
        step();
        bus.wr_en = 1'b0;
        lat = 1;
        while (!bus.rd_valid && lat < 20) begin
            step();
            lat++;
        end
        check("single_latency", lat, 3 + PIPELINE);
        check("single_data", bus.rd_data, 32'hA5A5_0001);
        step();
        check("single_empty", bus.fill_cnt, 0);

        // Fill to full with the consumer stalled, then overflow attempt.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = i;
            step();
        end
        check("fill_full", bus.full, 1);
        check("fill_cnt16", bus.fill_cnt, DEPTH);
        bus.wr_data = 32'hDEAD_0016;
        step();
        check("ovf_after_drop", bus.ovf_err, OVF_ON);
        check("fill_after_drop", bus.fill_cnt, DEPTH);
        drain("fill");

        // Streaming: back-to-back pushes, no bubbles on the output.
        start = cyc; first_pop = -1; last_pop = -1; npops = 0;
        for (int i = 0; i < 64 + 20; i++) begin
            bus.wr_en = (i < 64); bus.wr_data = i; bus.rd_ready = 1'b1;
            if (bus.rd_valid) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                npops++;
            end
            step();
        end
        check("stream_latency", first_pop - start, 3 + PIPELINE);
        check("stream_span", last_pop - first_pop, 63);
        check("stream_pops", npops, 64);

        // Random backpressure with random pushes.
        acc_cnt = 0; guard = 0;
        while (acc_cnt < 200 && guard < 5000) begin
            bus.wr_en    = ($urandom_range(0, 9) < 7);
            bus.wr_data  = $urandom;
            bus.rd_ready = $urandom_range(0, 1);
            if (bus.wr_en && q.size() != DEPTH) acc_cnt++;
            step();
            guard++;
        end
        check("random_pushes", acc_cnt, 200);
        drain("random");

        // Move pointers to 10, hold 8 entries, then push+pop every cycle.
        k = (10 - (n_push % DEPTH) + DEPTH) % DEPTH;
        for (int i = 0; i < k; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = $urandom; bus.rd_ready = 1'b1;
            step();
        end
        drain("align");
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'h5000_0000 + i;
            step();
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("wrap_fill8", bus.fill_cnt, 8);
        for (int i = 0; i < 40; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = $urandom; bus.rd_ready = 1'b1;
            check("wrap_valid", bus.rd_valid, 1);
            step();
        end
        check("wrap_fill_end", bus.fill_cnt, 8);
        drain("wrap");

        // Reset while reads are in flight.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'h7700_0000 + i;
            step();
        end
        bus.wr_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        n_push = 0; n_issue = 0; ovf_hit = 0; stall_prev = 0;
        bus.wr_en = 1'b1; bus.wr_data = 32'h0000_1234; bus.rd_ready = 1'b1;
        step();
        bus.wr_en = 1'b0;
        lat = 1;
        while (!bus.rd_valid && lat < 20) begin
            step();
            lat++;
        end
        check("post_rst_latency", lat, 3 + PIPELINE);
        check("post_rst_data", bus.rd_data, 32'h0000_1234);
        step();
        for (int i = 0; i < 4; i++) step();
        check("post_rst_empty", bus.fill_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
